// File: rtl/priority_range_decoder_if.sv
// priority_range_decoder_if: pair stream in, decoded range out
// master drives data_left_i/data_right_i/data_val_i and observes the results;
// slave (the decoder) returns left_idx_o/right_idx_o/mask_o/span_o/zero_o/err_o/data_val_o.
interface priority_range_decoder_if #(parameter int WIDTH = 5);
    localparam int IDX_W = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH + 1);
    logic [WIDTH-1:0] data_left_i;
    logic [WIDTH-1:0] data_right_i;
    logic             data_val_i;
    logic [IDX_W-1:0] left_idx_o;
    logic [IDX_W-1:0] right_idx_o;
    logic [WIDTH-1:0] mask_o;
    logic [CNT_W-1:0] span_o;
    logic             zero_o;
    logic             err_o;
    logic             data_val_o;
    modport master (
        output data_left_i, data_right_i, data_val_i,
        input  left_idx_o, right_idx_o, mask_o, span_o, zero_o, err_o, data_val_o
    );
    modport slave (
        input  data_left_i, data_right_i, data_val_i,
        output left_idx_o, right_idx_o, mask_o, span_o, zero_o, err_o, data_val_o
    );
endinterface

// File: rtl/priority_range_decoder.sv
// priority_range_decoder: decodes one-hot left/right pairs into indices, fill mask and span
// clk_i, rst_ni (async active-low) plain; bus (slave) carries the input pair stream
// and the registered results, valid two cycles after data_val_i.
module priority_range_decoder #(
    parameter int WIDTH = 5
) (
    input logic                     clk_i,
    input logic                     rst_ni,
    priority_range_decoder_if.slave bus
);
    localparam int IDX_W = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH + 1);

    // Index bit b is the OR of every input bit whose position has bit b set.
    function automatic logic [IDX_W-1:0] enc(input logic [WIDTH-1:0] w);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) r |= w[i] ? IDX_W'(i) : '0;
        return r;
    endfunction

    function automatic logic onehot(input logic [WIDTH-1:0] w);
        return (|w) && ((w & (w - WIDTH'(1))) == '0);
    endfunction

    logic             v1_q;
    logic [IDX_W-1:0] lidx1_q, ridx1_q;
    logic             lone1_q, rone1_q, lzero1_q, rzero1_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v1_q     <= 1'b0;
            lidx1_q  <= '0;
            ridx1_q  <= '0;
            lone1_q  <= 1'b0;
            rone1_q  <= 1'b0;
            lzero1_q <= 1'b0;
            rzero1_q <= 1'b0;
        end else begin
            v1_q <= bus.data_val_i;
            if (bus.data_val_i) begin
                lidx1_q  <= enc(bus.data_left_i);
                ridx1_q  <= enc(bus.data_right_i);
                lone1_q  <= onehot(bus.data_left_i);
                rone1_q  <= onehot(bus.data_right_i);
                lzero1_q <= ~|bus.data_left_i;
                rzero1_q <= ~|bus.data_right_i;
            end
        end
    end

    logic             ok;
    logic             val_q;
    logic [IDX_W-1:0] lidx_d, lidx_q, ridx_d, ridx_q;
    logic [WIDTH-1:0] mask_d, mask_q;
    logic [CNT_W-1:0] span_d, span_q;
    logic             zero_d, zero_q, err_d, err_q;

    always_comb begin
        ok     = lone1_q & rone1_q & (lidx1_q >= ridx1_q);
        zero_d = lzero1_q & rzero1_q;
        err_d  = ~ok & ~zero_d;
        lidx_d = ok ? lidx1_q : '0;
        ridx_d = ok ? ridx1_q : '0;
        span_d = ok ? CNT_W'(lidx1_q) - CNT_W'(ridx1_q) + CNT_W'(1) : '0;
        mask_d = '0;
        for (int i = 0; i < WIDTH; i++)
            mask_d[i] = ok && (i >= int'(ridx1_q)) && (i <= int'(lidx1_q));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            val_q  <= 1'b0;
            lidx_q <= '0;
            ridx_q <= '0;
            mask_q <= '0;
            span_q <= '0;
            zero_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            val_q <= v1_q;
            if (v1_q) begin
                lidx_q <= lidx_d;
                ridx_q <= ridx_d;
                mask_q <= mask_d;
                span_q <= span_d;
                zero_q <= zero_d;
                err_q  <= err_d;
            end
        end
    end

    assign bus.data_val_o  = val_q;
    assign bus.left_idx_o  = lidx_q;
    assign bus.right_idx_o = ridx_q;
    assign bus.mask_o      = mask_q;
    assign bus.span_o      = span_q;
    assign bus.zero_o      = zero_q;
    assign bus.err_o       = err_q;
endmodule
